n163_ram_arb: RTL

- Single-port arbiter and address sequencer for the N163 128x8 sound/wavetable RAM.
- Shares the RAM between two requesters:
  - the CPU data port ($4800-$4FFF), addressed through the $F800-$FFFF address/auto-increment register;
  - the sound channel sequencer, through a req/gnt handshake.
- Sits between the mapper CPU bus decode and the sound RAM macro. The sound engine never drives the RAM directly.

---
 rtl/n163_pkg.sv | 16 +
 rtl/n163_addr_reg.sv | 43 ++++
 rtl/n163_ram_arb.sv | 120 ++++++++++++
 3 files changed

// File: rtl/n163_pkg.sv
// Shared constants and types for the N163 wavetable RAM arbiter.
package n163_pkg;

    localparam int         N163_RAM_DEPTH = 128;
    localparam logic [4:0] REG_DATA_PAGE  = 5'b01001;
    localparam logic [4:0] REG_ADDR_PAGE  = 5'b11111;
    localparam logic [6:0] CHAN_BASE      = 7'h40;
    localparam logic [6:0] CHAN_CFG_ADDR  = 7'h7F;

    typedef enum logic [1:0] {
        RD_NONE = 2'd0,
        RD_CPU  = 2'd1,
        RD_SND  = 2'd2
    } rd_src_t;

endpackage

// File: rtl/n163_addr_reg.sv
// CPU-side RAM address register ($F800-$FFFF) with optional post-access auto-increment.
module n163_addr_reg #(
    parameter int ADDR_W = 7,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic [DATA_W-1:0] load_val_i,
    input  logic              step_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic              ainc_o
);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ainc_q, ainc_d;

    // A load in the same cycle as a data access takes precedence over the step.
    always_comb begin
        addr_d = addr_q;
        ainc_d = ainc_q;
        if (load_i) begin
            addr_d = load_val_i[ADDR_W-1:0];
            ainc_d = load_val_i[DATA_W-1];
        end else if (step_i && ainc_q) begin
            addr_d = addr_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q <= '0;
            ainc_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            ainc_q <= ainc_d;
        end
    end

    assign addr_o = addr_q;
    assign ainc_o = ainc_q;

endmodule

// File: rtl/n163_ram_arb.sv
// N163 sound RAM arbiter: CPU data port always wins, sound sequencer uses req/gnt.
// Optional starvation monitor enabled by defining N163_ARB_STALL_EN.
module n163_ram_arb
    import n163_pkg::*;
#(
    parameter int ADDR_W    = 7,
    parameter int DATA_W    = 8,
    parameter int STALL_MAX = 4
) (
    input  logic              m2,
    input  logic              map_rst_n,
    input  logic [15:0]       cpu_addr,
    input  logic [DATA_W-1:0] cpu_din,
    input  logic              cpu_rw,
    output logic [DATA_W-1:0] cpu_dout,
    input  logic              snd_req,
    input  logic              snd_we,
    input  logic [ADDR_W-1:0] snd_addr,
    input  logic [DATA_W-1:0] snd_wdata,
    output logic              snd_gnt,
    output logic              snd_rvalid,
    output logic [DATA_W-1:0] snd_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              snd_starved
);

    logic              addr_hit, data_hit, cpu_sel;
    logic [ADDR_W-1:0] addr_q;
    logic              ainc_q;
    logic [ADDR_W-1:0] ram_addr_q;
    rd_src_t           rd_src_q, rd_src_d;
    logic [DATA_W-1:0] cpu_dout_q;
    logic              unused_addr_bits;

    assign addr_hit = (cpu_addr[15:11] == REG_ADDR_PAGE);
    assign data_hit = (cpu_addr[15:11] == REG_DATA_PAGE);
    assign unused_addr_bits = ^cpu_addr[10:0];

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    assign cpu_sel = data_hit & map_rst_n;
    assign snd_gnt = snd_req & ~data_hit & map_rst_n;

    n163_addr_reg #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W)
    ) u_addr_reg (
        .clk       (m2),
        .rst_n     (map_rst_n),
        .load_i    (addr_hit & ~cpu_rw),
        .load_val_i(cpu_din),
        .step_i    (data_hit),
        .addr_o    (addr_q),
        .ainc_o    (ainc_q)
    );

    always_comb begin
        ram_addr  = ram_addr_q;
        ram_we    = 1'b0;
        ram_wdata = snd_wdata;
        rd_src_d  = RD_NONE;
        if (cpu_sel) begin
            ram_addr  = addr_q;
            ram_we    = ~cpu_rw;
            ram_wdata = cpu_din;
            if (cpu_rw) rd_src_d = RD_CPU;
        end else if (snd_gnt) begin
            ram_addr  = snd_addr;
            ram_we    = snd_we;
            ram_wdata = snd_wdata;
            if (!snd_we) rd_src_d = RD_SND;
        end
    end

    always_ff @(posedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            ram_addr_q <= '0;
            rd_src_q   <= RD_NONE;
            cpu_dout_q <= '0;
        end else begin
            if (cpu_sel || snd_gnt) ram_addr_q <= ram_addr;
            rd_src_q <= rd_src_d;
            if (rd_src_q == RD_CPU) cpu_dout_q <= ram_rdata;
        end
    end

    assign cpu_dout   = cpu_dout_q;
    assign snd_rvalid = (rd_src_q == RD_SND);
    assign snd_rdata  = snd_rvalid ? ram_rdata : '0;

`ifdef N163_ARB_STALL_EN
    logic [2:0] stall_cnt_q, stall_cnt_d;
    logic       starved_q;

    always_comb begin
        stall_cnt_d = 3'd0;
        if (snd_req && !snd_gnt)
            stall_cnt_d = (stall_cnt_q == 3'd7) ? stall_cnt_q : stall_cnt_q + 3'd1;
    end

    always_ff @(posedge m2 or negedge map_rst_n) begin
        if (!map_rst_n) begin
            stall_cnt_q <= 3'd0;
            starved_q   <= 1'b0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            starved_q   <= (int'(stall_cnt_d) >= STALL_MAX);
        end
    end

    assign snd_starved = starved_q;
`else
    logic unused_stall_max;
    assign unused_stall_max = (STALL_MAX != 0);
    assign snd_starved      = 1'b0;
`endif

endmodule
